// File: rtl/fft_frame_sequencer_if.sv
// Bundle of the sample-buffer ports and the two FFT Avalon-ST streams used by
// fft_frame_sequencer. The master side is the sequencer; the slave side is the
// buffer RAM plus FFT core seen from the parent.
interface fft_frame_sequencer_if #(
    parameter int AW = 13
) ();
    // Sample buffer write port
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [31:0]   buf_wr_data;
    // Sample buffer read port (fixed 1-cycle read latency)
    logic [AW-1:0] buf_rd_addr;
    logic [31:0]   buf_rd_data;
    // FFT sink (input) stream, ready latency 0
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic [31:0]   sink_real;
    logic          sink_ready;
    // FFT source (output) stream
    logic          source_valid;
    logic          source_sop;
    logic          source_eop;
    logic [31:0]   source_real;
    logic [31:0]   source_imag;
    logic          source_ready;

    modport master (
        output buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_addr,
        input  buf_rd_data,
        output sink_valid, sink_sop, sink_eop, sink_real,
        input  sink_ready,
        input  source_valid, source_sop, source_eop, source_real, source_imag,
        output source_ready
    );

    modport slave (
        input  buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_addr,
        output buf_rd_data,
        input  sink_valid, sink_sop, sink_eop, sink_real,
        output sink_ready,
        output source_valid, source_sop, source_eop, source_real, source_imag,
        input  source_ready
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for the tuner FFT path: captures one frame of audio
// samples into the external buffer, streams it into the FFT with full
// backpressure, then scans the FFT output for the strongest lower-half bin.
module fft_frame_sequencer #(
    parameter int FRAME_LEN = 8192,
    parameter int AW        = $clog2(FRAME_LEN)
) (
    input  logic                  CLOCK_50,
    input  logic                  AUD_ADCLRCK,
    input  logic                  i_enable,
    input  logic                  i_smp_valid,
    input  logic [31:0]           i_smp_data,
    fft_frame_sequencer_if.master bus,
    output logic [AW-1:0]         o_peak_bin,
    output logic [32:0]           o_peak_mag,
    output logic                  o_result_valid,
    output logic                  o_drop_flag,
    output logic                  o_busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RESULT  = 3'd4
    } state_t;

    // Two's-complement magnitude; the most negative value maps to 2^31,
    // which still fits in 32 unsigned bits.
    function automatic logic [31:0] f_abs32(input logic [31:0] v);
        logic [31:0] r;
        if (v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // |re| + |im| widened to 33 bits so the 2^31 + 2^31 corner cannot overflow.
    function automatic logic [32:0] f_mag(input logic [31:0] re, input logic [31:0] im);
        return {1'b0, f_abs32(re)} + {1'b0, f_abs32(im)};
    endfunction

    state_t        r_state;
    state_t        w_next;

    logic [AW-1:0] r_wr_cnt;
    logic [AW-1:0] r_rd_ptr;      // next buffer address to read
    logic [AW-1:0] r_rd_cur;      // address of the beat currently presented
    logic          r_rd_done;     // all FRAME_LEN reads issued
    logic          r_sink_valid;
    logic          r_sink_sop;
    logic          r_sink_eop;

    logic [AW-1:0] r_bin_cnt;
    logic [AW-1:0] r_max_bin;
    logic [32:0]   r_max_mag;
    logic [AW-1:0] r_peak_bin;
    logic [32:0]   r_peak_mag;
    logic          r_result_valid;
    logic          r_drop_flag;
    logic          r_busy;
    logic          r_source_ready;

    logic          w_wr_fire;
    logic          w_wr_last;
    logic          w_rd_issue;
    logic          w_sink_acc;
    logic          w_eop_acc;
    logic          w_src_acc;
    logic          w_src_last;
    logic [AW-1:0] w_bin;
    logic [32:0]   w_mag;
    logic          w_cand;
    logic [AW-1:0] w_base_bin;
    logic [32:0]   w_base_mag;
    logic [AW-1:0] w_max_bin;
    logic [32:0]   w_max_mag;

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        w_wr_fire  = (r_state == ST_CAPTURE) && i_smp_valid;
        w_wr_last  = w_wr_fire && (r_wr_cnt == LAST_ADDR);
        w_sink_acc = r_sink_valid && bus.sink_ready;
        w_eop_acc  = w_sink_acc && r_sink_eop;
        // A new read may only be launched when the presented beat is empty
        // or leaving this cycle, so the read data never overruns it.
        w_rd_issue = (r_state == ST_STREAM) && !r_rd_done &&
                     (!r_sink_valid || bus.sink_ready);
        w_src_acc  = bus.source_valid && r_source_ready;
        w_src_last = w_src_acc && bus.source_eop;
    end

    // Frame state register.
    always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_next = ST_CAPTURE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (w_wr_last) begin
                    w_next = ST_STREAM;
                end else begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_STREAM: begin
                if (w_eop_acc) begin
                    w_next = ST_DRAIN;
                end else begin
                    w_next = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (w_src_last) begin
                    w_next = ST_RESULT;
                end else begin
                    w_next = ST_DRAIN;
                end
            end
            ST_RESULT: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Capture write counter; the AW-bit counter wraps to 0 on the last write.
    always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            r_wr_cnt <= ADDR_ZERO;
        end else if (w_wr_fire) begin
            r_wr_cnt <= r_wr_cnt + ADDR_ONE;
        end else begin
            r_wr_cnt <= r_wr_cnt;
        end
    end

    // Read sequencing and sink framing. The buffer's own read register acts as
    // the output data register: when no new read is issued the last address is
    // re-presented, so sink_real holds while the FFT stalls.
    always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            r_rd_ptr     <= ADDR_ZERO;
            r_rd_cur     <= ADDR_ZERO;
            r_rd_done    <= 1'b0;
            r_sink_valid <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
        end else if (r_state != ST_STREAM) begin
            r_rd_ptr     <= ADDR_ZERO;
            r_rd_cur     <= ADDR_ZERO;
            r_rd_done    <= 1'b0;
            r_sink_valid <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
        end else if (w_rd_issue) begin
            r_rd_cur     <= r_rd_ptr;
            r_rd_ptr     <= r_rd_ptr + ADDR_ONE;
            r_rd_done    <= (r_rd_ptr == LAST_ADDR);
            r_sink_valid <= 1'b1;
            r_sink_sop   <= (r_rd_ptr == ADDR_ZERO);
            r_sink_eop   <= (r_rd_ptr == LAST_ADDR);
        end else if (w_sink_acc) begin
            r_sink_valid <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
        end else begin
            r_sink_valid <= r_sink_valid;
            r_sink_sop   <= r_sink_sop;
            r_sink_eop   <= r_sink_eop;
        end
    end

    // Per-beat magnitude and running-maximum update for the FFT output.
    always_comb begin
        if (bus.source_sop) begin
            w_bin      = ADDR_ZERO;
            w_base_bin = ADDR_ZERO;
            w_base_mag = 33'd0;
        end else begin
            w_bin      = r_bin_cnt;
            w_base_bin = r_max_bin;
            w_base_mag = r_max_mag;
        end
        w_mag  = f_mag(bus.source_real, bus.source_imag);
        // Bins 1 .. FRAME_LEN/2-1 only: DC and the mirrored half are skipped.
        w_cand = (w_bin != ADDR_ZERO) && (w_bin[AW-1] == 1'b0);
        if (w_src_acc && w_cand && (w_mag > w_base_mag)) begin
            w_max_bin = w_bin;
            w_max_mag = w_mag;
        end else if (w_src_acc) begin
            w_max_bin = w_base_bin;
            w_max_mag = w_base_mag;
        end else begin
            w_max_bin = r_max_bin;
            w_max_mag = r_max_mag;
        end
    end

    // Bin counter and running maximum registers.
    always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            r_bin_cnt <= ADDR_ZERO;
            r_max_bin <= ADDR_ZERO;
            r_max_mag <= 33'd0;
        end else if (w_src_acc) begin
            r_bin_cnt <= w_bin + ADDR_ONE;
            r_max_bin <= w_max_bin;
            r_max_mag <= w_max_mag;
        end else begin
            r_bin_cnt <= r_bin_cnt;
            r_max_bin <= r_max_bin;
            r_max_mag <= r_max_mag;
        end
    end

    // Result registers, loaded with the final maximum as the last bin is
    // accepted so they are valid during the RESULT cycle.
    always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            r_peak_bin     <= ADDR_ZERO;
            r_peak_mag     <= 33'd0;
            r_result_valid <= 1'b0;
        end else if (w_src_last) begin
            r_peak_bin     <= w_max_bin;
            r_peak_mag     <= w_max_mag;
            r_result_valid <= 1'b1;
        end else begin
            r_peak_bin     <= r_peak_bin;
            r_peak_mag     <= r_peak_mag;
            r_result_valid <= 1'b0;
        end
    end

    // Sticky overrun flag plus registered status decoded from the next state.
    always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            r_drop_flag    <= 1'b0;
            r_busy         <= 1'b0;
            r_source_ready <= 1'b0;
        end else begin
            r_drop_flag    <= r_drop_flag ||
                              (i_smp_valid && i_enable && (r_state != ST_CAPTURE));
            r_busy         <= (w_next != ST_IDLE);
            r_source_ready <= (w_next == ST_DRAIN);
        end
    end

    // Buffer write port is driven straight from the strobe (zero-latency write).
    assign bus.buf_wr_en    = w_wr_fire;
    assign bus.buf_wr_addr  = r_wr_cnt;
    assign bus.buf_wr_data  = w_wr_fire ? i_smp_data : 32'd0;
    assign bus.buf_rd_addr  = w_rd_issue ? r_rd_ptr : r_rd_cur;

    assign bus.sink_valid   = r_sink_valid;
    assign bus.sink_sop     = r_sink_sop;
    assign bus.sink_eop     = r_sink_eop;
    assign bus.sink_real    = r_sink_valid ? bus.buf_rd_data : 32'd0;
    assign bus.source_ready = r_source_ready;

    assign o_peak_bin       = r_peak_bin;
    assign o_peak_mag       = r_peak_mag;
    assign o_result_valid   = r_result_valid;
    assign o_drop_flag      = r_drop_flag;
    assign o_busy           = r_busy;

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Frame-level controller for the tuner's FFT path. It captures FRAME_LEN audio samples into an external single-port sample buffer, then streams them into the FFT core over an Avalon-ST sink with full backpressure. It then consumes the FFT source stream and reports the strongest bin of the lower half-spectrum. It replaces ad-hoc FIFO read/write sequencing and sits between the audio-in strobe domain and the pitch/display logic.

## Interface
- FRAME_LEN, 8192: samples per FFT frame; power of two, equal to the FFT's configured fftpts.
- AW, 13: log2(FRAME_LEN); width of buffer addresses and bin indices.
- CLOCK_50  in  1  system clock; all logic is clocked on its rising edge.
- AUD_ADCLRCK  in  1  reset, asynchronous, active-high; clock CLOCK_50.
- enable  in  1  when high, the block starts a new frame each time it returns to IDLE.
- smp_valid  in  1  one-cycle strobe per audio sample, already synchronous to CLOCK_50.
- smp_data  in  32  signed sample; valid when smp_valid is high.
- buf_wr_en / buf_wr_addr / buf_wr_data  out  1/AW/32  sample buffer write port.
- buf_rd_addr  out  AW  buffer read address; the buffer has a fixed 1-cycle read latency.
- buf_rd_data  in  32  read data for the address presented on the previous cycle.
- sink_valid / sink_sop / sink_eop  out  1  FFT input framing.
- sink_real  out  32  FFT input data. sink_imag is tied to 0 at the parent level.
- sink_ready  in  1  FFT input ready; Avalon-ST ready latency 0.
- source_valid / source_sop / source_eop  in  1  FFT output framing.
- source_real / source_imag  in  32  signed FFT output bin.
- source_ready  out  1  high only in state DRAIN.
- peak_bin  out  AW  index of the strongest bin.
- peak_mag  out  33  |re|+|im| of that bin.
- result_valid  out  1  one-cycle pulse when peak_bin and peak_mag update.
- drop_flag  out  1  sticky; set when smp_valid arrives outside CAPTURE while enable=1.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE → CAPTURE when enable=1.
  - CAPTURE → STREAM after FRAME_LEN writes.
  - STREAM → DRAIN when the beat with sink_eop is accepted.
  - DRAIN → RESULT when the beat with source_eop is accepted.
  - RESULT → IDLE unconditionally.
- CAPTURE:
  - Each smp_valid asserts buf_wr_en in the same cycle, with buf_wr_addr = wr_cnt and buf_wr_data = smp_data.
  - wr_cnt increments and wraps to 0 on the FRAME_LEN-th write, which also triggers the exit to STREAM.
  - Deasserting enable mid-frame does not abort the frame.
- STREAM:
  - Reads addresses 0..FRAME_LEN-1 in order.
  - A single output register holds sink_real/sop/eop.
  - A read is issued only when the output register is empty, or is being accepted this cycle (sink_valid & sink_ready). This sustains 1 beat/cycle when sink_ready stays high.
  - sink_sop is set on the address-0 beat and sink_eop on the address-(FRAME_LEN-1) beat.
  - While sink_ready=0, sink_valid, sink_real and the framing flags are held stable.
- DRAIN:
  - Every accepted source beat (source_valid & source_ready) increments bin_cnt; source_sop forces bin_cnt=0 for that beat.
  - mag = |source_real| + |source_imag|, computed at 33 bits with no overflow. abs(-2^31) = 2^31.
  - Only bins 1..FRAME_LEN/2-1 are candidates; DC and the mirror half are ignored.
  - The running max updates only on strictly greater mag, so the lowest index wins ties.
  - The running max is cleared on source_sop.
- RESULT:
  - peak_bin and peak_mag are loaded from the running max and result_valid pulses.
  - If no candidate exceeded 0, the block reports peak_bin=0 and peak_mag=0.
- drop_flag is cleared only by reset.
- Reset mid-operation:
  - State returns to IDLE and all counters and the running max clear.
  - The FFT must be reset alongside; a partial frame is never resumed.

## Timing
- Reset values:
  - All outputs 0, including peak_bin, peak_mag, drop_flag and busy.
  - source_ready is 0.
  - buf_wr_en and sink_valid are 0.
- Write path: combinational from smp_valid to buf_wr_en, i.e. a 0-cycle latency write.
- STREAM entry: the first read address is issued in the first STREAM cycle; sink_valid rises 1 cycle later.
- Streaming a frame with sink_ready held high takes exactly FRAME_LEN+1 cycles.
- The cycle after sink_eop is accepted, the state is DRAIN and source_ready=1.
- result_valid is asserted the cycle after the source_eop beat is accepted.
- Idle gap: with enable held high, CAPTURE re-enters 2 cycles after the result_valid pulse (RESULT→IDLE→CAPTURE).

## Test plan
- Reset check: hold AUD_ADCLRCK high for 5 cycles → every output is 0 and busy=0. Release with enable=1 → busy=1 next cycle.
- Capture: 8192 smp_valid strobes of data=n → writes appear at addr n, in order; the state enters STREAM after the 8192nd strobe.
- Backpressure: toggle sink_ready pseudo-randomly → 8192 beats, data 0..8191 in order, no duplicates or drops; data is stable while stalled; sop on beat 0, eop on beat 8191.
- Peak detection:
  - Source frame with all bins 0 except bin 37 (re=-1000, im=500) → result_valid pulse with peak_bin=37, peak_mag=1500.
  - A larger value in bin 0 or bin 5000 is ignored.
- Tie and extreme values: bins 10 and 20 both equal 2^31 (re=-2^31, im=0) → peak_bin=10, peak_mag=2147483648.
- Abort and drop: assert reset in mid-STREAM → IDLE with outputs 0, and the next frame restarts at address 0. A smp_valid during DRAIN sets drop_flag, which stays 1 until reset.
